argmax_stream_pipe: RTL and testbench
=====================================

Name: argmax_stream_pipe

Overview:
- Pipelined, parametrised argmax classifier that turns per-class clause sums into a winning class index and score.
- Sits between the class-sum accumulator and the AXI-Stream master output; accepts one vector per cycle under valid/ready.
- Replaces the single-shot, edge-triggered classify stage with a throughput-1 pipeline: configurable register depth, backpressure, selectable tie-break, score reporting and a result counter.

Parameters:
- CLASS_NUM, 10, number of classes (>=2)
- WEIGHT_LENGTH, 14, signed class-sum width
- C_M00_AXIS_TDATA_WIDTH, 64, output word width (>= WEIGHT_LENGTH+16)
- LEVELS_PER_STAGE, 1, comparator tree levels per pipeline register (1..INDEX_LENGTH)
- TIE_HIGH, 0, 0: lowest index wins ties; 1: highest index wins ties
- OUT_SCORE, 1, 1: pack winning score into y; 0: upper bits zero
- INDEX_LENGTH (derived), max(1,$clog2(CLASS_NUM)); TREE_WIDTH = 2**INDEX_LENGTH; STAGES = ceil(INDEX_LENGTH/LEVELS_PER_STAGE)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  c_sum vector valid
- s_ready  out  1  block can accept c_sum this cycle
- c_sum  in  CLASS_NUM x WEIGHT_LENGTH signed  per-class sums, element k = class k
- m_valid  out  1  y holds a result
- m_ready  in  1  downstream accepts y
- y  out  C_M00_AXIS_TDATA_WIDTH  packed result
- result_count  out  32  number of results accepted downstream

Behaviour:
- Reset (rst_n low, async): m_valid=0, y=0, result_count=0, all pipeline valid bits and data registers=0; takes effect immediately, not on clk. In-flight vectors discarded. First acceptance possible on first rising edge after rst_n rises.
- Accept: transfer when s_valid && s_ready at rising edge; c_sum captured into leaf register with indices 0..CLASS_NUM-1.
- Leaves CLASS_NUM..TREE_WIDTH-1 are padding, tagged invalid. An invalid leaf never wins against a valid one, regardless of value or TIE_HIGH.
- Compare node: signed compare. Strictly greater value wins. On equal values: TIE_HIGH=0 picks lower index, TIE_HIGH=1 picks higher index.
- Registers: after leaf stage, a pipeline register follows every LEVELS_PER_STAGE tree levels; the last register feeds y/m_valid.
- Latency: with m_ready held high, m_valid rises STAGES+1 cycles after the accepting edge. CLASS_NUM=10, LPS=1 gives 5 cycles; LPS=2 gives 3; LPS=4 gives 2.
- Throughput: one vector per cycle.
- Stall: s_ready = !(m_valid && !m_ready), combinational.
  - While stalled, every pipeline register and y hold their values; no data lost, duplicated or reordered.
  - Bubbles are not compressed.
- Output handshake: y and m_valid stable while m_valid && !m_ready. m_valid may drop only after a transfer.
- y packing:
  - y[15:0] = winning index, zero-extended.
  - y[C_M00_AXIS_TDATA_WIDTH-1:16] = winning score sign-extended if OUT_SCORE=1, else 0.
  - y unchanged when no new result.
- result_count: +1 on each m_valid && m_ready edge; wraps 2^32-1 -> 0.
- Simultaneous accept and output transfer in the same cycle are legal and independent.

Test Plan:
- Single vector, CLASS_NUM=10, W=14, LPS=1, all sums 0 except class 7=100 -> m_valid high exactly 5 cycles after accept, y[15:0]=7, y[63:16]=100, result_count=1.
- Tie, classes 2 and 5 both 300, others -5 -> TIE_HIGH=0 gives index 2; TIE_HIGH=1 gives index 5; score 300 in both.
- All classes -8192 (most negative), CLASS_NUM=10 (6 pad leaves) -> TIE_HIGH=0 gives index 0, TIE_HIGH=1 gives index 9; never 10..15; y[63:16] = sign-extended -8192.
- Back-to-back 8 vectors with winners 0..7, m_ready low cycles 3-5 after first m_valid:
  - s_ready low during the stall;
  - outputs 0..7 in order with no loss or duplicates;
  - result_count=8.
- rst_n asserted mid-stream with 3 vectors in flight, asynchronously between edges -> m_valid, y and result_count 0 before next edge; no stale result after release.
- CLASS_NUM=2, LPS=1, OUT_SCORE=0; c_sum={-3,4} -> INDEX_LENGTH=1, latency 2, y=1, y[63:16]=0.

Source files
------------

// File: rtl/argmax_stream_pipe_if.sv
// argmax_stream_pipe_if: valid/ready bundle for the argmax classifier.
// Carries the c_sum input handshake (s_valid/s_ready/c_sum) and the packed
// result handshake (m_valid/m_ready/y). slave = the classifier, master = the
// surrounding logic that feeds sums and consumes results.
interface argmax_stream_pipe_if #(
  parameter int CLASS_NUM = 10,
  parameter int WEIGHT_LENGTH = 14,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
);
  logic s_valid;
  logic s_ready;
  logic [CLASS_NUM-1:0][WEIGHT_LENGTH-1:0] c_sum;
  logic m_valid;
  logic m_ready;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] y;
  modport slave (input s_valid, c_sum, m_ready, output s_ready, m_valid, y);
  modport master (output s_valid, c_sum, m_ready, input s_ready, m_valid, y);
endinterface

// File: rtl/argmax_stream_pipe.sv
// argmax_stream_pipe: pipelined argmax over per-class sums, throughput 1.
// Ports: clk, rst_n (async, active-low); io (slave): s_valid/s_ready/c_sum in,
// m_valid/m_ready/y out, y = {score (sign-extended or 0), 16-bit index};
// result_count = results accepted downstream (wraps).
module argmax_stream_pipe #(
  parameter int CLASS_NUM = 10,
  parameter int WEIGHT_LENGTH = 14,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int TIE_HIGH = 0,
  parameter int OUT_SCORE = 1
) (
  input logic clk,
  input logic rst_n,
  argmax_stream_pipe_if.slave io,
  output logic [31:0] result_count
);
  localparam int IL = ($clog2(CLASS_NUM) < 1) ? 1 : $clog2(CLASS_NUM);
  localparam int TW = 1 << IL;
  localparam int W = WEIGHT_LENGTH;
  localparam int C = C_M00_AXIS_TDATA_WIDTH;
  logic adv;
  logic [TW-1:0][W-1:0] leaf_d;
  logic [C-1:0] y_n;
  // Whole pipeline advances together; it freezes only while a result waits.
  assign adv = !(io.m_valid && !io.m_ready);
  assign io.s_ready = adv;
  assign leaf_d = (TW*W)'(io.c_sum);
  for (genvar l = 0; l <= IL; l++) begin : lv
    localparam int N = TW >> l;
    logic v;
    logic [N-1:0][W-1:0] val;
    logic [N-1:0][IL-1:0] idx;
    if (l == 0) begin : g_leaf
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v <= 1'b0;
          val <= '0;
        end else if (adv) begin
          v <= io.s_valid;
          val <= leaf_d;
        end
      always_comb
        for (int n = 0; n < N; n++) idx[n] = IL'(n);
    end else begin : g_node
      logic [N-1:0] tk;
      logic [N-1:0][W-1:0] cv;
      logic [N-1:0][IL-1:0] ci;
      // A subtree is real iff its first leaf is a real class, so padding is a
      // compile-time property of node position and never needs a stored tag.
      always_comb
        for (int n = 0; n < N; n++) begin
          tk[n] = (((2*n+1) << (l-1)) < CLASS_NUM) &&
                  (!(((2*n) << (l-1)) < CLASS_NUM) ||
                   $signed(lv[l-1].val[2*n+1]) > $signed(lv[l-1].val[2*n]) ||
                   (TIE_HIGH != 0 && lv[l-1].val[2*n+1] == lv[l-1].val[2*n]));
          cv[n] = tk[n] ? lv[l-1].val[2*n+1] : lv[l-1].val[2*n];
          ci[n] = tk[n] ? lv[l-1].idx[2*n+1] : lv[l-1].idx[2*n];
        end
      if (l % LEVELS_PER_STAGE == 0 || l == IL) begin : g_reg
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) begin
            v <= 1'b0;
            val <= '0;
            idx <= '0;
          end else if (adv) begin
            v <= lv[l-1].v;
            val <= cv;
            idx <= ci;
          end
      end else begin : g_comb
        assign v = lv[l-1].v;
        assign val = cv;
        assign idx = ci;
      end
    end
  end
  assign y_n = {OUT_SCORE != 0 ? (C-16)'($signed(lv[IL].val[0])) : {(C-16){1'b0}},
                16'(lv[IL].idx[0])};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      io.m_valid <= 1'b0;
      io.y <= '0;
      result_count <= '0;
    end else begin
      if (adv) io.m_valid <= lv[IL].v;
      if (adv && lv[IL].v) io.y <= y_n;
      if (io.m_valid && io.m_ready) result_count <= result_count + 32'd1;
    end
endmodule

// File: tb/tb_argmax_stream_pipe.sv
// tb_argmax_stream_pipe: scoreboard bench over four parameterisations of the classifier.
module tb_argmax_stream_pipe;
  logic clk, rst_n, sv, mr, all_ready;
  logic [31:0] rc [4];
  logic mv [4];
  logic sr [4];
  logic [63:0] yv [4];
  int checks = 0, errors = 0;
  int acc [$];
  int rd [4];
  logic pstall [4];
  logic [63:0] py [4];
  int vals [13][10] = '{
    '{0, 0, 0, 0, 0, 0, 0, 100, 0, 0},
    '{-5, -5, 300, -5, -5, 300, -5, -5, -5, -5},
    '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5},
    '{-3, 4, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192},
    '{500, -1, 2, 3, 4, 5, 6, 7, 8, 9},
    '{-100, 8191, 0, 0, 0, 0, 0, 0, 0, -8192},
    '{1, 2, 3, -4, -5, -6, -7, -8, -9, -10},
    '{-20, -30, -40, -10, -50, -60, -70, -80, -90, -11},
    '{0, 0, 0, 0, 42, 41, 41, 0, 0, 40},
    '{7, 7, 7, 7, 7, 8, 7, 7, 7, 7},
    '{-8192, -8192, -8192, -8192, -8192, -8192, -8191, -8192, -8192, -8192},
    '{1, -1, 1, -1, 1, -1, 1, 2, 1, -1}};
  int lo [13] = '{7, 2, 0, 9, 1, 0, 1, 2, 3, 4, 5, 6, 7};
  int hi [13] = '{7, 5, 9, 9, 1, 0, 1, 2, 3, 4, 5, 6, 7};
  int sc [13] = '{100, 300, -8192, 5, 4, 500, 8191, 3, -10, 42, 8, -8191, 2};
  int i2 [13] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
  int explat [4] = '{5, 3, 2, 2};

  argmax_stream_pipe_if #(.CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64)) io0 ();
  argmax_stream_pipe_if #(.CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64)) io1 ();
  argmax_stream_pipe_if #(.CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64)) io2 ();
  argmax_stream_pipe_if #(.CLASS_NUM(2), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64)) io3 ();

  argmax_stream_pipe #(.CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64),
    .LEVELS_PER_STAGE(1), .TIE_HIGH(0), .OUT_SCORE(1)) u0 (.clk(clk), .rst_n(rst_n), .io(io0), .result_count(rc[0]));
  argmax_stream_pipe #(.CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64),
    .LEVELS_PER_STAGE(2), .TIE_HIGH(1), .OUT_SCORE(1)) u1 (.clk(clk), .rst_n(rst_n), .io(io1), .result_count(rc[1]));
  argmax_stream_pipe #(.CLASS_NUM(10), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64),
    .LEVELS_PER_STAGE(4), .TIE_HIGH(0), .OUT_SCORE(1)) u2 (.clk(clk), .rst_n(rst_n), .io(io2), .result_count(rc[2]));
  argmax_stream_pipe #(.CLASS_NUM(2), .WEIGHT_LENGTH(14), .C_M00_AXIS_TDATA_WIDTH(64),
    .LEVELS_PER_STAGE(1), .TIE_HIGH(0), .OUT_SCORE(0)) u3 (.clk(clk), .rst_n(rst_n), .io(io3), .result_count(rc[3]));

  assign all_ready = io0.s_ready & io1.s_ready & io2.s_ready & io3.s_ready;
  assign io0.s_valid = sv & all_ready;
  assign io1.s_valid = sv & all_ready;
  assign io2.s_valid = sv & all_ready;
  assign io3.s_valid = sv & all_ready;
  assign io0.m_ready = mr;
  assign io1.m_ready = mr;
  assign io2.m_ready = mr;
  assign io3.m_ready = mr;
  assign mv[0] = io0.m_valid;
  assign mv[1] = io1.m_valid;
  assign mv[2] = io2.m_valid;
  assign mv[3] = io3.m_valid;
  assign sr[0] = io0.s_ready;
  assign sr[1] = io1.s_ready;
  assign sr[2] = io2.s_ready;
  assign sr[3] = io3.s_ready;
  assign yv[0] = io0.y;
  assign yv[1] = io1.y;
  assign yv[2] = io2.y;
  assign yv[3] = io3.y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // u1 breaks ties high, u3 only sees classes 0..1 and reports no score.
  function automatic logic [63:0] exp_y(input int k, input int id);
    logic [47:0] s = 48'(sc[id]);
    int ix = (k == 1) ? hi[id] : lo[id];
    return (k == 3) ? 64'(i2[id]) : {s, 16'(ix)};
  endfunction

  always @(negedge clk)
    for (int k = 0; k < 4; k++)
      if (rst_n) begin
        if (pstall[k]) chk(mv[k] && yv[k] == py[k], $sformatf("u%0d_hold", k), yv[k], py[k]);
        if (!mr && mv[k]) chk(!sr[k], $sformatf("u%0d_s_ready_stall", k), 64'(sr[k]), 64'd0);
        if (mr) chk(sr[k], $sformatf("u%0d_s_ready_free", k), 64'(sr[k]), 64'd1);
        if (mv[k] && mr) begin
          if (rd[k] < acc.size()) begin
            chk(yv[k] == exp_y(k, acc[rd[k]]), $sformatf("u%0d_y_vec%0d", k, acc[rd[k]]), yv[k], exp_y(k, acc[rd[k]]));
            rd[k]++;
          end else chk(1'b0, $sformatf("u%0d_unexpected_output", k), yv[k], 64'd0);
        end
        pstall[k] = mv[k] && !mr;
        py[k] = yv[k];
      end

  task automatic set_vec(input int id);
    for (int n = 0; n < 10; n++) begin
      io0.c_sum[n] = 14'(vals[id][n]);
      io1.c_sum[n] = 14'(vals[id][n]);
      io2.c_sum[n] = 14'(vals[id][n]);
    end
    for (int n = 0; n < 2; n++) io3.c_sum[n] = 14'(vals[id][n]);
  endtask

  task automatic send(input int id);
    int t = 0;
    bit ok = 1'b0;
    set_vec(id);
    sv = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = all_ready;
      if (ok) acc.push_back(id);
      @(posedge clk);
      t++;
    end
    if (!ok) chk(1'b0, "send_timeout", 64'(id), 64'd0);
    #1 sv = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    bit done = 1'b0;
    while (!done && t < 200) begin
      @(posedge clk);
      #1 t++;
      done = 1'b1;
      for (int k = 0; k < 4; k++) if (rd[k] != acc.size()) done = 1'b0;
    end
    chk(done, "drain", 64'(rd[0]), 64'(acc.size()));
  endtask

  task automatic check_rc(input int n);
    for (int k = 0; k < 4; k++) chk(rc[k] == 32'(n), $sformatf("u%0d_result_count", k), 64'(rc[k]), 64'(n));
  endtask

  task automatic flush_sb();
    acc.delete();
    for (int k = 0; k < 4; k++) begin
      rd[k] = 0;
      pstall[k] = 1'b0;
    end
  endtask

  initial begin
    int lat [4];
    int cnt;
    rst_n = 1'b0;
    sv = 1'b0;
    mr = 1'b1;
    flush_sb();
    set_vec(0);
    #12;
    for (int k = 0; k < 4; k++) begin
      chk(!mv[k], $sformatf("u%0d_reset_m_valid", k), 64'(mv[k]), 64'd0);
      chk(yv[k] == 64'd0, $sformatf("u%0d_reset_y", k), yv[k], 64'd0);
      chk(sr[k], $sformatf("u%0d_reset_s_ready", k), 64'(sr[k]), 64'd1);
    end
    check_rc(0);
    #4 rst_n = 1'b1;
    send(0);
    lat = '{0, 0, 0, 0};
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (mv[k] && lat[k] == 0) lat[k] = c;
    end
    for (int k = 0; k < 4; k++) chk(lat[k] == explat[k], $sformatf("u%0d_latency", k), 64'(lat[k]), 64'(explat[k]));
    check_rc(1);
    for (int i = 1; i <= 4; i++) send(i);
    wait_drain();
    check_rc(5);
    fork
      for (int i = 5; i <= 12; i++) send(i);
      begin
        int t = 0;
        while (!mv[0] && t < 100) begin
          @(posedge clk);
          #1 t++;
        end
        chk(mv[0], "u0_first_valid_wait", 64'(mv[0]), 64'd1);
        repeat (3) @(posedge clk);
        #1 mr = 1'b0;
        repeat (3) @(posedge clk);
        #1 mr = 1'b1;
      end
    join
    wait_drain();
    check_rc(13);
    send(5);
    send(6);
    send(7);
    #2 rst_n = 1'b0;
    flush_sb();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk(!mv[k], $sformatf("u%0d_async_m_valid", k), 64'(mv[k]), 64'd0);
      chk(yv[k] == 64'd0, $sformatf("u%0d_async_y", k), yv[k], 64'd0);
    end
    check_rc(0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (mv[k]) cnt++;
    end
    chk(cnt == 0, "stale_after_reset", 64'(cnt), 64'd0);
    send(4);
    wait_drain();
    check_rc(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
